// File: rtl/pwm_capture.sv
// PWM receive-side capture: measures high time and rise-to-rise period of an
// asynchronous PWM line and recovers the generator's duty code.
module pwm_capture #(
  parameter int unsigned CBITS     = 14,
  parameter int unsigned CODE_BITS = 3,
  parameter int unsigned PER_TOL   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pwm_in,
  output logic                 meas_valid,
  output logic [CBITS:0]       high_cnt,
  output logic [CBITS:0]       period_cnt,
  output logic [CODE_BITS-1:0] code,
  output logic                 locked,
  output logic                 period_err,
  output logic                 stuck
);

  localparam int unsigned  W         = CBITS + 1;
  localparam int unsigned  SHIFT     = CBITS - 1 - CODE_BITS;
  localparam int unsigned  NOM       = 32'd1 << CBITS;
  localparam logic [W-1:0] CNT_MAX   = {W{1'b1}};
  localparam logic [W-1:0] PER_LO    = W'(NOM - PER_TOL);
  localparam logic [W-1:0] PER_HI    = W'(NOM + PER_TOL);
  localparam logic [1:0]   GOOD_LOCK = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic                 prev_q, prev_d;
  logic [W-1:0]         pcnt_q, pcnt_d;
  logic [W-1:0]         hcnt_q, hcnt_d;
  logic [W-1:0]         hold_q, hold_d;
  logic [1:0]           good_q, good_d;
  logic                 meas_valid_q, meas_valid_d;
  logic [W-1:0]         high_cnt_q, high_cnt_d;
  logic [W-1:0]         period_cnt_q, period_cnt_d;
  logic [CODE_BITS-1:0] code_q, code_d;
  logic                 locked_q, locked_d;
  logic                 period_err_q, period_err_d;
  logic                 stuck_q, stuck_d;

  logic                 line_c;
  logic                 rise_c;
  logic                 fall_c;
  logic                 timeout_c;
  logic                 per_bad_c;
  logic                 publish_c;
  logic [W-1:0]         pub_h_c;

  // Two-flop synchronizer followed by an edge register
  always_comb begin
    sync_d = {sync_q[0], pwm_in};
    prev_d = sync_q[1];
  end

  assign line_c = sync_q[1];
  assign rise_c = line_c & ~prev_q;
  assign fall_c = ~line_c & prev_q;

  // Saturating period / high-time counters, both restarted by a rise
  always_comb begin
    pcnt_d = pcnt_q;
    hcnt_d = hcnt_q;
    if (rise_c) begin
      pcnt_d = W'(1);
      hcnt_d = W'(1);
    end else begin
      if (pcnt_q != CNT_MAX) pcnt_d = pcnt_q + W'(1);
      if (line_c && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + W'(1);
    end
  end

  // Fires once, on the cycle pcnt steps onto all-ones
  assign timeout_c = !rise_c && (pcnt_q == (CNT_MAX - W'(1)));
  assign per_bad_c = (pcnt_q < PER_LO) || (pcnt_q > PER_HI);

  // Capture FSM plus registered measurement outputs
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    good_d       = good_q;
    meas_valid_d = 1'b0;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    code_d       = code_q;
    locked_d     = locked_q;
    period_err_d = period_err_q;
    stuck_d      = stuck_q;
    publish_c    = 1'b0;
    pub_h_c      = hold_q;

    unique case (state_q)
      S_IDLE: begin
        if (rise_c) state_d = S_HIGH;
      end
      S_HIGH: begin
        if (fall_c) begin
          hold_d  = hcnt_q;
          state_d = S_LOW;
        end else if (rise_c) begin
          // Rise without a seen fall: close the period using the live count
          pub_h_c   = hcnt_q;
          publish_c = 1'b1;
        end
      end
      S_LOW: begin
        if (rise_c) begin
          publish_c = 1'b1;
          state_d   = S_HIGH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rise_c) stuck_d = 1'b0;

    if (publish_c) begin
      meas_valid_d = 1'b1;
      high_cnt_d   = pub_h_c;
      period_cnt_d = pcnt_q;
      code_d       = CODE_BITS'(pub_h_c >> SHIFT);
      period_err_d = per_bad_c;
      if (per_bad_c) begin
        good_d = 2'd0;
      end else if (good_q != GOOD_LOCK) begin
        good_d = good_q + 2'd1;
      end
      locked_d = (good_d == GOOD_LOCK);
    end

    if (timeout_c) begin
      stuck_d  = 1'b1;
      locked_d = 1'b0;
      good_d   = 2'd0;
      state_d  = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sync_q       <= '0;
      prev_q       <= 1'b0;
      pcnt_q       <= '0;
      hcnt_q       <= '0;
      hold_q       <= '0;
      good_q       <= '0;
      meas_valid_q <= 1'b0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      code_q       <= '0;
      locked_q     <= 1'b0;
      period_err_q <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      pcnt_q       <= pcnt_d;
      hcnt_q       <= hcnt_d;
      hold_q       <= hold_d;
      good_q       <= good_d;
      meas_valid_q <= meas_valid_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      code_q       <= code_d;
      locked_q     <= locked_d;
      period_err_q <= period_err_d;
      stuck_q      <= stuck_d;
    end
  end

  assign meas_valid = meas_valid_q;
  assign high_cnt   = high_cnt_q;
  assign period_cnt = period_cnt_q;
  assign code       = code_q;
  assign locked     = locked_q;
  assign period_err = period_err_q;
  assign stuck      = stuck_q;

endmodule
